seq_pattern_detector: RTL and testbench
=======================================

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 6, pattern length in bits (2..32).
REQ-002 Parameter PAT_INIT, default 6'b101001, pattern value after reset.
REQ-003 Parameter CNT_W, default 6, hit-counter width.
REQ-004 Port i_clk  input  1  single clock, all state on rising edge.
REQ-005 Port i_reset  input  1  asynchronous, active-high reset.
REQ-006 Port i_valid  input  1  i_data is sampled on this edge.
REQ-007 Port i_data  input  1  serial data bit, MSB of pattern first.
REQ-008 Port i_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 Port i_pat_load  input  1  load i_pat as the new pattern.
REQ-010 Port i_pat  input  PAT_W  new pattern value.
REQ-011 Port i_cnt_clr  input  1  synchronous clear of the hit counter.
REQ-012 Port o_pattern_found  output  1  one-cycle hit pulse.
REQ-013 Port o_count  output  CNT_W  number of hits since reset or clear.
REQ-014 Port o_count_end  output  1  sticky flag: o_count saturated at 2^CNT_W-1.

Function
REQ-015 Shift register hist (PAT_W-1 bits) shall take {hist, i_data} on each edge with i_valid=1, and hold otherwise.
REQ-016 Fill counter fill (0..PAT_W-1) shall count valid bits since the last reset, load or non-overlap hit, and saturate at PAT_W-1.
REQ-017 FSM states: FILL (fill < PAT_W-1) and ARMED (fill = PAT_W-1); FILL->ARMED when fill reaches PAT_W-1; ARMED->FILL on load, or on a hit with i_overlap=0.
REQ-018 Hit condition: state ARMED, i_valid=1, and {hist, i_data} == pattern register.
REQ-019 On a hit, o_pattern_found shall be 1 for exactly the next cycle, giving latency 1 clock from the completing bit.
REQ-020 Overlap mode shall keep hist and fill on a hit, so a suffix of the pattern may start the next match.
REQ-021 Non-overlap mode shall clear fill to 0 on a hit, so the next match needs PAT_W fresh bits.
REQ-022 i_overlap shall be sampled at each hit, and changing it mid-stream shall take effect from the next hit.
REQ-023 i_pat_load=1 shall load the pattern register, clear fill, and suppress hit evaluation on that edge; it overrides i_valid.
REQ-024 o_count shall increment by 1 per hit in the same edge that sets o_pattern_found.
REQ-025 o_count shall saturate at 2^CNT_W-1 and never wrap; o_count_end shall be set on that edge and stay set.
REQ-026 i_cnt_clr=1 shall zero o_count and o_count_end; a simultaneous hit shall give o_count=1 and still pulse o_pattern_found.
REQ-027 Back-to-back hits shall keep o_pattern_found high on consecutive cycles.

Reset
REQ-028 i_reset=1 shall immediately force hist=0, fill=0, state FILL, pattern register=PAT_INIT, o_pattern_found=0, o_count=0 and o_count_end=0.
REQ-029 Reset released mid-sequence shall discard any partial match, and bits before release shall never contribute to a hit.

Configuration
REQ-030 With macro SEQ_DET_MASK_EN defined, the block shall add port i_mask (input, PAT_W), loaded with i_pat on i_pat_load (reset value all-ones); bit positions with mask=0 are don't-care in the compare.
REQ-031 Without SEQ_DET_MASK_EN, there shall be no i_mask port and all PAT_W bits shall be compared exactly.

Structure
REQ-032 Package seq_det_pkg shall hold the FSM state typedef (FILL, ARMED) and the default constants PAT_W_DEF=6, PAT_INIT_DEF=6'b101001 and CNT_W_DEF=6.
REQ-033 The saturating hit counter shall be a sub-module sat_counter (params WIDTH; inputs inc, clr; outputs count, at_max).

Verification
REQ-034 Defaults, overlap=1, stream 101001 01001 -> two hits: o_pattern_found high 1 cycle after bit 6 and after bit 11, o_count=2.
REQ-035 Same stream, overlap=0 -> one hit after bit 6 only, o_count=1.
REQ-036 Send 1010 then assert reset, then 01 -> no hit; then a full 101001 after reset -> one hit.
REQ-037 CNT_W=2, 4 hits in overlap mode -> o_count stops at 3, o_count_end=1 from the 3rd hit; i_cnt_clr then gives o_count=0 and o_count_end=0.
REQ-038 Load i_pat=6'b111000 mid-stream with i_valid=1 -> the bit on the load edge is ignored, 101001 no longer hits, 111000 hits after 6 new bits.
REQ-039 SEQ_DET_MASK_EN, i_pat=6'b101001, i_mask=6'b110011 -> stream 101101 produces a hit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_t;

    localparam int         PAT_W_DEF    = 6;
    localparam logic [5:0] PAT_INIT_DEF = 6'b101001;
    localparam int         CNT_W_DEF    = 6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky "reached maximum" flag; clear wins
// over the old value but a simultaneous increment still counts.
module sat_counter #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             at_max_reg;
    logic             at_max_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_reg != MAX_VAL)) begin
            count_next = count_reg + WIDTH'(1);
        end
        at_max_next = (clr ? 1'b0 : at_max_reg) | (count_next == MAX_VAL);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg  <= '0;
            at_max_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            at_max_reg <= at_max_next;
        end
    end

    assign count  = count_reg;
    assign at_max = at_max_reg;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with run-time pattern load, overlap control and a
// saturating hit counter. Optional per-bit compare mask: SEQ_DET_MASK_EN.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W    = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_INIT_DEF),
    parameter int               CNT_W    = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_data,
    input  logic             i_overlap,
    input  logic             i_pat_load,
    input  logic [PAT_W-1:0] i_pat,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] i_mask,
`endif
    input  logic             i_cnt_clr,
    output logic             o_pattern_found,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_end
);

    localparam int                FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

    logic [PAT_W-2:0]  hist_reg;
    logic [FILL_W-1:0] fill_reg;
    det_state_t        state_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  mask;
    logic              found_reg;

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  bit_match;
    logic              hit;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_reg;
    assign mask = mask_reg;
`else
    assign mask = '1;
`endif

    // The incoming bit completes the window, so a match is seen on the same edge.
    assign window = {hist_reg, i_data};

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_match[gi] = ~mask[gi] | (window[gi] == pat_reg[gi]);
        end
    endgenerate

    assign hit = (state_reg == ARMED) && i_valid && !i_pat_load && (&bit_match);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            state_reg <= FILL;
            pat_reg   <= PAT_INIT;
            found_reg <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_reg  <= '1;
`endif
        end else begin
            found_reg <= hit;
            if (i_pat_load) begin
                pat_reg   <= i_pat;
`ifdef SEQ_DET_MASK_EN
                mask_reg  <= i_mask;
`endif
                fill_reg  <= '0;
                state_reg <= FILL;
            end else if (i_valid) begin
                hist_reg <= window[PAT_W-2:0];
                case (state_reg)
                    FILL: begin
                        fill_reg <= fill_reg + FILL_W'(1);
                        if (fill_reg == FILL_LAST) begin
                            state_reg <= ARMED;
                        end
                    end
                    ARMED: begin
                        // Non-overlapping: the next match must be built from fresh bits.
                        if (hit && !i_overlap) begin
                            fill_reg  <= '0;
                            state_reg <= FILL;
                        end else begin
                            fill_reg <= FILL_MAX;
                        end
                    end
                    default: begin
                        fill_reg  <= '0;
                        state_reg <= FILL;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_hit_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .inc     (hit),
        .clr     (i_cnt_clr),
        .count   (o_count),
        .at_max  (o_count_end)
    );

    assign o_pattern_found = found_reg;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised and directed bench for seq_pattern_detector against a bit-history
// reference model; runs one default instance and one with a 2-bit counter.
`timescale 1ns/1ps
module tb_seq_pattern_detector;

    localparam int PW   = 6;
    localparam int CWA  = 6;
    localparam int CWB  = 2;
    localparam int MAXA = (1 << CWA) - 1;
    localparam int MAXB = (1 << CWB) - 1;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_valid;
    logic          i_data;
    logic          i_overlap;
    logic          i_pat_load;
    logic [PW-1:0] i_pat;
    logic [PW-1:0] i_mask;
    logic          i_cnt_clr;

    logic           found_a;
    logic [CWA-1:0] count_a;
    logic           end_a;
    logic           found_b;
    logic [CWB-1:0] count_b;
    logic           end_b;

    seq_pattern_detector dut_a (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .i_data          (i_data),
        .i_overlap       (i_overlap),
        .i_pat_load      (i_pat_load),
        .i_pat           (i_pat),
`ifdef SEQ_DET_MASK_EN
        .i_mask          (i_mask),
`endif
        .i_cnt_clr       (i_cnt_clr),
        .o_pattern_found (found_a),
        .o_count         (count_a),
        .o_count_end     (end_a)
    );

    seq_pattern_detector #(.CNT_W(CWB)) dut_b (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .i_data          (i_data),
        .i_overlap       (i_overlap),
        .i_pat_load      (i_pat_load),
        .i_pat           (i_pat),
`ifdef SEQ_DET_MASK_EN
        .i_mask          (i_mask),
`endif
        .i_cnt_clr       (i_cnt_clr),
        .o_pattern_found (found_b),
        .o_count         (count_b),
        .o_count_end     (end_b)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    string phase = "init";

    // Reference model: remembers every accepted bit and how many arrived since
    // the last reset, load or non-overlapping hit.
    logic [63:0]   m_bits;
    int            m_fresh;
    logic [PW-1:0] m_pat;
    logic [PW-1:0] m_mask;
    bit            m_found;
    int            m_cnt_a, m_cnt_b;
    bit            m_end_a, m_end_b;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0d, expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits  = '0;
        m_fresh = 0;
        m_pat   = 6'b101001;
        m_mask  = '1;
        m_found = 0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_end_a = 0;
        m_end_b = 0;
    endtask

    task automatic model_edge();
        bit hit;
        hit = 0;
        if (i_pat_load) begin
            m_pat = i_pat;
`ifdef SEQ_DET_MASK_EN
            m_mask = i_mask;
`endif
            m_fresh = 0;
        end else if (i_valid) begin
            m_bits = {m_bits[62:0], i_data};
            if (m_fresh < 1000) m_fresh++;
            if (m_fresh >= PW && (((m_bits[PW-1:0] ^ m_pat) & m_mask) == '0)) begin
                hit = 1;
                if (!i_overlap) m_fresh = 0;
            end
        end
        m_found = hit;
        if (i_cnt_clr) begin
            m_cnt_a = 0; m_end_a = 0;
            m_cnt_b = 0; m_end_b = 0;
        end
        if (hit && m_cnt_a < MAXA) m_cnt_a++;
        if (hit && m_cnt_b < MAXB) m_cnt_b++;
        if (m_cnt_a == MAXA) m_end_a = 1;
        if (m_cnt_b == MAXB) m_end_b = 1;
    endtask

    task automatic check_all();
        check_val("found_a", 32'(found_a), 32'(m_found));
        check_val("found_b", 32'(found_b), 32'(m_found));
        check_val("count_a", 32'(count_a), 32'(m_cnt_a));
        check_val("count_b", 32'(count_b), 32'(m_cnt_b));
        check_val("end_a",   32'(end_a),   32'(m_end_a));
        check_val("end_b",   32'(end_b),   32'(m_end_b));
    endtask

    task automatic step(input bit v, input bit d, input bit ov, input bit ld,
                        input logic [PW-1:0] pat, input bit clr);
        i_valid = v; i_data = d; i_overlap = ov; i_pat_load = ld; i_pat = pat; i_cnt_clr = clr;
        @(posedge i_clk);
        model_edge();
        #1;
        $display("[%0t] %s v=%b d=%b ov=%b ld=%b pat=%b clr=%b -> found=%b cnt_a=%0d end_a=%b cnt_b=%0d end_b=%b",
                 $time, phase, v, d, ov, ld, pat, clr, found_a, count_a, end_a, count_b, end_b);
        check_all();
    endtask

    task automatic send(input logic [31:0] bits, input int n, input bit ov);
        logic [31:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], ov, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        i_valid = 0; i_data = 0; i_pat_load = 0; i_cnt_clr = 0; i_mask = '1;
        i_reset = 1;
        #1;
        model_reset();
        check_all();
        @(posedge i_clk);
        #1;
        i_reset = 0;
    endtask

    initial begin
        i_reset = 1; i_valid = 0; i_data = 0; i_overlap = 1; i_pat_load = 0;
        i_pat = '0; i_mask = '1; i_cnt_clr = 0;
        model_reset();
        #12;
        phase = "reset";
        do_reset();
        check_val("rst_found", 32'(found_a), 0);
        check_val("rst_count", 32'(count_a), 0);
        check_val("rst_end",   32'(end_a),   0);

        phase = "overlap";
        send(32'b10100101001, 11, 1'b1);
        check_val("two_hits", 32'(count_a), 2);

        phase = "nonoverlap";
        do_reset();
        send(32'b10100101001, 11, 1'b0);
        check_val("one_hit", 32'(count_a), 1);

        phase = "reset_mid";
        do_reset();
        send(32'b1010, 4, 1'b1);
        do_reset();
        send(32'b01, 2, 1'b1);
        check_val("no_hit_after_rst", 32'(count_a), 0);
        send(32'b101001, 6, 1'b1);
        check_val("hit_after_rst", 32'(count_a), 1);

        phase = "saturate2";
        do_reset();
        send(32'b101001010010100101001, 21, 1'b1);
        check_val("sat_count_b", 32'(count_b), 3);
        check_val("sat_end_b",   32'(end_b),   1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        check_val("clr_count_b", 32'(count_b), 0);
        check_val("clr_end_b",   32'(end_b),   0);

        phase = "load";
        do_reset();
        send(32'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 6'b111000, 1'b0);
        send(32'b101001, 6, 1'b1);
        check_val("old_pat_dead", 32'(count_a), 0);
        send(32'b111000, 6, 1'b1);
        check_val("new_pat_hit", 32'(count_a), 1);

        phase = "clr_hit";
        step(1'b0, 1'b0, 1'b1, 1'b1, 6'b101001, 1'b0);
        send(32'b10100, 5, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        check_val("clr_hit_count", 32'(count_a), 1);
        check_val("clr_hit_found", 32'(found_a), 1);

        phase = "saturate6";
        step(1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        check_val("sat_count_a", 32'(count_a), MAXA);
        check_val("sat_end_a",   32'(end_a),   1);

`ifdef SEQ_DET_MASK_EN
        phase = "mask";
        do_reset();
        i_mask = 6'b110011;
        step(1'b0, 1'b0, 1'b1, 1'b1, 6'b101001, 1'b0);
        i_mask = '1;
        send(32'b101101, 6, 1'b1);
        check_val("mask_hit", 32'(count_a), 1);
`endif

        phase = "random";
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit v, d, ov, ld, clr;
            logic [PW-1:0] pat;
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                v   = ($urandom_range(9) < 8);
                d   = $urandom_range(1);
                ov  = (((i / 60) % 2) == 0) ? 1'b1 : bit'($urandom_range(1));
                ld  = ($urandom_range(49) == 0);
                clr = ($urandom_range(39) == 0);
                pat = PW'($urandom);
                if ($urandom_range(3) == 0) pat = 6'b101101;
                i_mask = PW'($urandom) | 6'b110000;
                step(v, d, ov, ld, pat, clr);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
